// File: rtl/rfm_pkg.sv
// Shared types, default sizing and the saturating counter helper for the RFM row tracker.
package rfm_pkg;

  localparam int DEF_NUM_ENTRY      = 512;
  localparam int DEF_NUM_ENTRY_BITS = 9;
  localparam int DEF_RFM_TH         = 649;
  localparam int DEF_ADDR_SIZE      = 18;
  localparam int DEF_CNT_SIZE       = 32;
  localparam int SAT_W              = 64;

  // Default-width view of one tracker entry; the bank redeclares it at its own widths.
  typedef struct packed {
    logic                     valid;
    logic [DEF_ADDR_SIZE-1:0] addr;
    logic [DEF_CNT_SIZE-1:0]  cnt;
  } rfm_entry_t;

  // Increment v, holding at the all-ones value of a w-bit counter (w < SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned       w);
    logic [SAT_W-1:0] lim;
    lim = (SAT_W'(1) << w) - SAT_W'(1);
    return (v >= lim) ? lim : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/rfm_argsel.sv
// Combined min/max selector over the tracker counters, lowest index wins every tie.
module rfm_argsel #(
  parameter int N  = 512,
  parameter int IW = 9,
  parameter int W  = 32
) (
  input  logic [N-1:0][W-1:0] cnt,
  input  logic [N-1:0]        valid,
  output logic [IW-1:0]       min_idx,
  output logic [W-1:0]        min_cnt,
  output logic [IW-1:0]       max_idx,
  output logic                max_found
);

  // Heap-ordered tree: leaves at N..2N-1, node g merges 2g (lower indices) and 2g+1.
  logic [W-1:0]  mn_cnt [1:2*N-1];
  logic [IW-1:0] mn_idx [1:2*N-1];
  logic [W-1:0]  mx_cnt [1:2*N-1];
  logic [IW-1:0] mx_idx [1:2*N-1];
  logic          mx_vld [1:2*N-1];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mn_cnt[N+i] = cnt[i];
      mn_idx[N+i] = IW'(i);
      mx_cnt[N+i] = cnt[i];
      mx_idx[N+i] = IW'(i);
      mx_vld[N+i] = valid[i];
    end
    for (int g = N-1; g >= 1; g--) begin
      if (mn_cnt[2*g+1] < mn_cnt[2*g]) begin
        mn_cnt[g] = mn_cnt[2*g+1];
        mn_idx[g] = mn_idx[2*g+1];
      end else begin
        mn_cnt[g] = mn_cnt[2*g];
        mn_idx[g] = mn_idx[2*g];
      end
      if (mx_vld[2*g+1] && (!mx_vld[2*g] || (mx_cnt[2*g+1] > mx_cnt[2*g]))) begin
        mx_cnt[g] = mx_cnt[2*g+1];
        mx_idx[g] = mx_idx[2*g+1];
      end else begin
        mx_cnt[g] = mx_cnt[2*g];
        mx_idx[g] = mx_idx[2*g];
      end
      mx_vld[g] = mx_vld[2*g] | mx_vld[2*g+1];
    end
    min_idx   = mn_idx[1];
    min_cnt   = mn_cnt[1];
    max_idx   = mx_idx[1];
    max_found = mx_vld[1];
  end

endmodule

// File: rtl/rfm_unit_bank.sv
// Per-bank Space-Saving activation tracker issuing one NRR for the hottest row per RFM.
// Optional RFM_AUTO_EN adds an RAA counter that raises an internal RFM every RFM_TH ACTs.
module rfm_unit_bank
  import rfm_pkg::*;
#(
  parameter int NUM_ENTRY      = DEF_NUM_ENTRY,
  parameter int NUM_ENTRY_BITS = DEF_NUM_ENTRY_BITS,
  parameter int RFM_TH         = DEF_RFM_TH,
  parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
  parameter int CNT_SIZE       = DEF_CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 act_cmd,
  input  logic [ADDR_SIZE-1:0] act_addr,
  input  logic                 rfm_cmd,
  output logic                 nrr_cmd,
  output logic [ADDR_SIZE-1:0] nrr_addr
);

  typedef struct packed {
    logic                 valid;
    logic [ADDR_SIZE-1:0] addr;
    logic [CNT_SIZE-1:0]  cnt;
  } entry_t;

  entry_t tbl [NUM_ENTRY];

  logic [NUM_ENTRY-1:0][CNT_SIZE-1:0] cnt_vec;
  logic [NUM_ENTRY-1:0]               valid_vec;
  logic                               hit;
  logic [NUM_ENTRY_BITS-1:0]          hit_idx;
  logic [NUM_ENTRY_BITS-1:0]          wr_idx;
  logic [NUM_ENTRY_BITS-1:0]          min_idx;
  logic [NUM_ENTRY_BITS-1:0]          max_idx;
  logic [CNT_SIZE-1:0]                min_cnt;
  logic [CNT_SIZE-1:0]                upd_base;
  logic [CNT_SIZE-1:0]                upd_cnt;
  logic                               max_found;
  logic                               rfm_pend;
  logic                               rfm_req;
  logic                               auto_rfm;

  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      cnt_vec[i]   = tbl[i].cnt;
      valid_vec[i] = tbl[i].valid;
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ENTRY-1; i >= 0; i--) begin
      if (tbl[i].valid && (tbl[i].addr == act_addr)) begin
        hit     = 1'b1;
        hit_idx = NUM_ENTRY_BITS'(i);
      end
    end
  end

  rfm_argsel #(
    .N  (NUM_ENTRY),
    .IW (NUM_ENTRY_BITS),
    .W  (CNT_SIZE)
  ) u_argsel (
    .cnt       (cnt_vec),
    .valid     (valid_vec),
    .min_idx   (min_idx),
    .min_cnt   (min_cnt),
    .max_idx   (max_idx),
    .max_found (max_found)
  );

  always_comb begin
    wr_idx   = hit ? hit_idx : min_idx;
    upd_base = hit ? tbl[hit_idx].cnt : min_cnt;
    upd_cnt  = CNT_SIZE'(sat_inc(SAT_W'(upd_base), CNT_SIZE));
  end

`ifdef RFM_AUTO_EN
  localparam int RAA_W = $clog2(RFM_TH + 1);

  logic [RAA_W-1:0] raa_cnt;

  assign auto_rfm = (raa_cnt == RAA_W'(RFM_TH));

  // Holds at the threshold so a long ACT burst cannot wrap past a pending request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raa_cnt <= '0;
    end else if (act_cmd) begin
      if (!auto_rfm) raa_cnt <= raa_cnt + RAA_W'(1);
    end else if (rfm_req) begin
      raa_cnt <= '0;
    end
  end
`else
  logic unused_rfm_th;

  assign auto_rfm      = 1'b0;
  assign unused_rfm_th = ^RFM_TH;
`endif

  assign rfm_req = rfm_cmd | rfm_pend | auto_rfm;

  // An ACT always wins the edge; any RFM seen alongside it waits as a single pending request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ENTRY; i++) tbl[i] <= '0;
      rfm_pend <= 1'b0;
      nrr_cmd  <= 1'b0;
      nrr_addr <= '0;
    end else begin
      nrr_cmd <= 1'b0;
      if (act_cmd) begin
        tbl[wr_idx] <= '{valid: 1'b1, addr: act_addr, cnt: upd_cnt};
        rfm_pend    <= rfm_req;
      end else if (rfm_req) begin
        rfm_pend <= 1'b0;
        if (max_found) begin
          nrr_cmd           <= 1'b1;
          nrr_addr          <= tbl[max_idx].addr;
          tbl[max_idx].cnt  <= min_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_rfm_unit_bank.sv
// Directed bench for rfm_unit_bank on a 4-entry, 4-bit-counter instance with a spec-level model.
module tb_rfm_unit_bank;

  localparam int N    = 4;
  localparam int NB   = 2;
  localparam int AW   = 18;
  localparam int CW   = 4;
  localparam int TH   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk      = 1'b0;
  logic          rstn     = 1'b0;
  logic          act_cmd  = 1'b0;
  logic [AW-1:0] act_addr = '0;
  logic          rfm_cmd  = 1'b0;
  logic          nrr_cmd;
  logic [AW-1:0] nrr_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rfm_unit_bank #(
    .NUM_ENTRY      (N),
    .NUM_ENTRY_BITS (NB),
    .RFM_TH         (TH),
    .ADDR_SIZE      (AW),
    .CNT_SIZE       (CW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .act_cmd  (act_cmd),
    .act_addr (act_addr),
    .rfm_cmd  (rfm_cmd),
    .nrr_cmd  (nrr_cmd),
    .nrr_addr (nrr_addr)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: table of rows with counts, pending RFM flag, RAA count.
  bit            m_valid [N];
  logic [AW-1:0] m_addr  [N];
  int            m_cnt   [N];
  bit            m_pend;
  bit            m_nrr;
  logic [AW-1:0] m_nrr_addr;
  int            m_raa;

  always @(posedge clk or negedge rstn) begin : model
    int hit, j, mx, mn;
    bit req;
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0;
        m_addr[i]  = '0;
        m_cnt[i]   = 0;
      end
      m_pend     = 0;
      m_nrr      = 0;
      m_nrr_addr = '0;
      m_raa      = 0;
    end else begin
      req = rfm_cmd || m_pend;
`ifdef RFM_AUTO_EN
      if (m_raa == TH) req = 1;
`endif
      m_nrr = 0;
      if (act_cmd) begin
        hit = -1;
        for (int i = 0; i < N; i++)
          if (hit < 0 && m_valid[i] && m_addr[i] == act_addr) hit = i;
        if (hit >= 0) begin
          m_cnt[hit] = (m_cnt[hit] < CMAX) ? m_cnt[hit] + 1 : CMAX;
        end else begin
          j = 0;
          for (int i = 1; i < N; i++) if (m_cnt[i] < m_cnt[j]) j = i;
          m_cnt[j]   = (m_cnt[j] < CMAX) ? m_cnt[j] + 1 : CMAX;
          m_valid[j] = 1;
          m_addr[j]  = act_addr;
        end
        if (m_raa < TH) m_raa++;
        m_pend = req;
      end else if (req) begin
        m_pend = 0;
        m_raa  = 0;
        mx = -1;
        for (int i = 0; i < N; i++)
          if (m_valid[i] && (mx < 0 || m_cnt[i] > m_cnt[mx])) mx = i;
        if (mx >= 0) begin
          mn = m_cnt[0];
          for (int i = 1; i < N; i++) if (m_cnt[i] < mn) mn = m_cnt[i];
          m_nrr      = 1;
          m_nrr_addr = m_addr[mx];
          m_cnt[mx]  = mn;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("nrr_cmd", 64'(nrr_cmd), 64'(m_nrr));
    chk("nrr_addr", 64'(nrr_addr), 64'(m_nrr_addr));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("e%0d.valid", i), 64'(dut.tbl[i].valid), 64'(m_valid[i]));
      chk($sformatf("e%0d.addr", i), 64'(dut.tbl[i].addr), 64'(m_addr[i]));
      chk($sformatf("e%0d.cnt", i), 64'(dut.tbl[i].cnt), 64'(m_cnt[i]));
    end
  end

  task automatic cyc(input bit a, input int ad, input bit r);
    @(negedge clk);
    act_cmd  = a;
    act_addr = AW'(ad);
    rfm_cmd  = r;
  endtask

  task automatic idle();
    cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    act_cmd = 0;
    rfm_cmd = 0;
    #2 rstn = 0;
    @(negedge clk);
    #2 rstn = 1;
  endtask

  task automatic lit_entry(input string nm, input int i, input bit v, input int a, input int c);
    chk({nm, ".valid"}, 64'(dut.tbl[i].valid), 64'(v));
    chk({nm, ".addr"}, 64'(dut.tbl[i].addr), 64'(a));
    chk({nm, ".cnt"}, 64'(dut.tbl[i].cnt), 64'(c));
  endtask

  task automatic lit_nrr(input string nm, input bit c, input int a);
    chk({nm, ".cmd"}, 64'(nrr_cmd), 64'(c));
    chk({nm, ".addr"}, 64'(nrr_addr), 64'(a));
  endtask

  initial begin
    int rows [6];
    rows = '{10, 11, 11, 12, 13, 14};

    repeat (2) @(negedge clk);
    #2 rstn = 1;
    lit_nrr("reset_nrr", 0, 0);
    lit_entry("reset_e0", 0, 0, 0, 0);

    // RFM against an empty table
    cyc(0, 0, 1);
    idle();
    lit_nrr("empty_rfm", 0, 0);
    idle();

    // ACT row 0 must not hit any invalid entry
    cyc(1, 0, 0);
    idle();
    lit_entry("act0_e0", 0, 1, 0, 1);
    lit_entry("act0_e1", 1, 0, 0, 0);
    cyc(1, 0, 0);
    idle();
    chk("act0_again_e0.cnt", 64'(dut.tbl[0].cnt), 64'd2);
    chk("act0_again_e1.valid", 64'(dut.tbl[1].valid), 64'd0);

    do_reset();
    repeat (3) cyc(1, 5, 0);
    cyc(0, 0, 1);
    lit_entry("row5_x3", 0, 1, 5, 3);
    idle();
    lit_nrr("row5_nrr", 1, 5);
    chk("row5_after_rfm.cnt", 64'(dut.tbl[0].cnt), 64'd0);
    idle();
    lit_nrr("row5_hold", 0, 5);

    // Eviction order on a 4-entry table
    do_reset();
    foreach (rows[k]) cyc(1, rows[k], 0);
    idle();
    lit_entry("evict14_e0", 0, 1, 14, 2);
    lit_entry("evict14_e2", 2, 1, 12, 1);
    cyc(1, 15, 0);
    idle();
    lit_entry("evict15_e2", 2, 1, 15, 2);
    cyc(0, 0, 1);
    idle();
    lit_nrr("evict_nrr", 1, 14);
    chk("evict_nrr_e0.cnt", 64'(dut.tbl[0].cnt), 64'd1);

    // Simultaneous ACT and RFM, then merged RFMs behind back-to-back ACTs
    do_reset();
    cyc(1, 7, 1);
    idle();
    lit_entry("simul_e0", 0, 1, 7, 1);
    chk("simul_first.cmd", 64'(nrr_cmd), 64'd0);
    idle();
    lit_nrr("simul_nrr", 1, 7);
    cyc(1, 8, 1);
    cyc(1, 9, 1);
    cyc(1, 8, 0);
    idle();
    chk("merge_wait.cmd", 64'(nrr_cmd), 64'd0);
    idle();
    lit_nrr("merge_nrr", 1, 8);
    idle();
    chk("merge_single.cmd", 64'(nrr_cmd), 64'd0);
    repeat (2) idle();

    // Reset while an RFM is pending
    do_reset();
    cyc(1, 20, 1);
    do_reset();
    idle();
    idle();
    lit_nrr("abort_nrr", 0, 0);
    chk("abort_e0.valid", 64'(dut.tbl[0].valid), 64'd0);

    // Counter saturation
    do_reset();
    repeat (20) cyc(1, 3, 0);
    idle();
    lit_entry("sat_e0", 0, 1, 3, CMAX);
    chk("sat_quiet.cmd", 64'(nrr_cmd), 64'd0);
    idle();
`ifdef RFM_AUTO_EN
    lit_nrr("sat_auto_nrr", 1, 3);
`else
    lit_nrr("sat_no_nrr", 0, 0);
`endif
    cyc(0, 0, 1);
    idle();
    lit_nrr("sat_rfm_nrr", 1, 3);
    chk("sat_rfm_e0.cnt", 64'(dut.tbl[0].cnt), 64'd0);

`ifdef RFM_AUTO_EN
    do_reset();
    repeat (3) cyc(1, 3, 0);
    idle();
    chk("auto_3.cmd", 64'(nrr_cmd), 64'd0);
    cyc(1, 3, 0);
    idle();
    chk("auto_4_wait.cmd", 64'(nrr_cmd), 64'd0);
    idle();
    lit_nrr("auto_4_nrr", 1, 3);
`endif

    repeat (3) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rfm_unit_bank.md
Name: rfm_unit_bank

Overview:
- Per-DRAM-bank row-activation tracker using the Space-Saving heavy-hitter algorithm.
- Holds NUM_ENTRY {row address, activation count} pairs. Every ACT updates the table.
- Every RFM command emits one Nearby-Row-Refresh (NRR) request for the hottest tracked row.
- Sits between the memory-controller command stream and the refresh-management logic.

Parameters:
- NUM_ENTRY, 512: number of tracked entries (power of two, ≥4).
- NUM_ENTRY_BITS, 9: log2(NUM_ENTRY), the entry index width.
- RFM_TH, 649: ACTs per RFM interval; used only when RFM_AUTO_EN is defined.
- ADDR_SIZE, 18: row address width.
- CNT_SIZE, 32: per-entry counter width.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- act_cmd  input  1  one-cycle ACT strobe.
- act_addr  input  ADDR_SIZE  row address of the ACT; valid while act_cmd=1.
- rfm_cmd  input  1  one-cycle RFM strobe.
- nrr_cmd  output  1  one-cycle NRR request.
- nrr_addr  output  ADDR_SIZE  row to refresh; valid while nrr_cmd=1, held otherwise.

Behaviour:
- Reset: all entries valid=0, addr=0, cnt=0; nrr_cmd=0; nrr_addr=0; internal pending flags=0. Reset mid-operation aborts any pending work.
- Entry state: valid, addr[ADDR_SIZE], cnt[CNT_SIZE]. Invalid entries have cnt=0.
- Match: an entry hits when valid=1 and addr==act_addr. At most one hit exists by construction; if several hit, the lowest index is used.
- Min search: the lowest-index entry with the smallest cnt, invalid entries included.
- Max search: the lowest-index valid entry with the largest cnt. Both searches are fully combinational over the table.
- ACT sampled (act_cmd=1 at a rising edge); the table is updated at that same edge and is visible one cycle later.
  - Hit: cnt ← cnt+1.
  - Miss: the min entry is overwritten: addr ← act_addr, valid ← 1, cnt ← min_cnt+1.
  - Counters saturate at 2^CNT_SIZE−1 and never wrap.
- RFM sampled (rfm_cmd=1), table holds ≥1 valid entry:
  - Next cycle: nrr_cmd=1 for exactly one cycle, with nrr_addr = max entry's addr, taken from the table state at the sampling edge.
  - At the sampling edge, the max entry's cnt ← the current min_cnt; valid is retained.
- RFM with an empty table: no NRR pulse; nrr_addr unchanged.
- Simultaneous act_cmd and rfm_cmd at one edge: the ACT is applied first. The RFM is held pending and processed at the next edge against the updated table, so nrr_cmd is delayed by one cycle.
  - Further RFMs arriving while one is pending are merged into it: one NRR is issued.
- A back-to-back ACT at the same edge as a pending RFM is processed the same way: ACT first, the RFM stays pending.
- The design only needs to support one ACT per cycle.

Optional Feature:
- Macro RFM_AUTO_EN.
- Defined:
  - An internal RAA counter (width ≥ clog2(RFM_TH+1)) increments on each ACT and clears whenever an RFM (external or internal) is processed.
  - When it reaches RFM_TH, an internal RFM is raised, with identical behaviour and priority to rfm_cmd; it is merged if an RFM is already pending.
- Undefined: no RAA counter; RFM_TH is unused; only rfm_cmd triggers NRR.

Decomposition:
- Package rfm_pkg:
  - entry struct typedef {valid, addr, cnt}.
  - Default parameter constants.
  - Saturating-increment function.
- One sub-module rfm_argsel: a parameterised comparator tree taking the cnt and valid vectors and returning min_idx, min_cnt, max_idx and max_found. It uses lowest-index tie-break and is instantiated once for both min and max.
- The table lives in rfm_unit_bank as flop arrays.

Test Plan:
- Reset then ACT addr 0: entry 0 = {1, 0, 1}; all other entries invalid. Address 0 must not falsely hit an invalid entry.
- ACT addr 5 three times: entry 0 = {5, 3}. Then rfm_cmd: nrr_cmd pulses one cycle later with nrr_addr=5, and entry 0 cnt ← 0 (table min).
- NUM_ENTRY=4: ACT rows 10, 11, 11, 12, 13, then 14.
  - Row 14 evicts entry 0 (row 10, cnt 1): entry 0 = {14, 2}.
  - The next ACT row 15 evicts entry 2 (row 12, cnt 1): entry 2 = {15, 2}.
- Simultaneous act_cmd (addr 7, new) and rfm_cmd on an empty table: entry 0 = {7, 1}; nrr_cmd asserts two cycles after the edge with nrr_addr=7.
- RFM on an empty table after reset: nrr_cmd stays 0 and nrr_addr stays 0.
- CNT_SIZE=4: 20 ACTs to row 3 → cnt holds at 15. With RFM_AUTO_EN and RFM_TH=4: the 4th ACT triggers an internal NRR with nrr_addr=3.
